// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker that rebuilds the controller phase
// sequence from the light patterns and flags encoding/order/timing/car violations.
`default_nettype none

module traffic_light_monitor #(
    parameter int GREEN_MIN    = 80,
    parameter int LR_GREEN_LEN = 80,
    parameter int YELLOW_LEN   = 20,
    parameter int ALLRED_LEN   = 1,
    parameter int STARVE_LIMIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hw_light,
    input  logic [2:0] lr_light,
    input  logic       lr_has_car,
    output logic [2:0] phase,
    output logic       err,
    output logic [2:0] err_code,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    localparam logic [2:0] c_ph_idle = 3'd0;
    localparam logic [2:0] c_ph_hwg  = 3'd1;
    localparam logic [2:0] c_ph_hwy  = 3'd2;
    localparam logic [2:0] c_ph_red1 = 3'd3;
    localparam logic [2:0] c_ph_lrg  = 3'd4;
    localparam logic [2:0] c_ph_lry  = 3'd5;
    localparam logic [2:0] c_ph_red2 = 3'd6;

    localparam logic [2:0] c_pat_hwg  = 3'd0;
    localparam logic [2:0] c_pat_hwy  = 3'd1;
    localparam logic [2:0] c_pat_red  = 3'd2;
    localparam logic [2:0] c_pat_lrg  = 3'd3;
    localparam logic [2:0] c_pat_lry  = 3'd4;
    localparam logic [2:0] c_pat_bad  = 3'd5;
    localparam logic [2:0] c_pat_none = 3'd6;

    localparam logic [2:0] c_code_none   = 3'd0;
    localparam logic [2:0] c_code_enc    = 3'd1;
    localparam logic [2:0] c_code_seq    = 3'd2;
    localparam logic [2:0] c_code_timing = 3'd3;
    localparam logic [2:0] c_code_nocar  = 3'd4;
    localparam logic [2:0] c_code_starve = 3'd5;

    localparam logic [2:0] c_red   = 3'b001;
    localparam logic [2:0] c_yel   = 3'b010;
    localparam logic [2:0] c_green = 3'b100;

    localparam logic [7:0] c_green_min = 8'(GREEN_MIN);
    localparam logic [7:0] c_lr_green  = 8'(LR_GREEN_LEN);
    localparam logic [7:0] c_yellow    = 8'(YELLOW_LEN);
    localparam logic [7:0] c_allred    = 8'(ALLRED_LEN);
    localparam logic [7:0] c_starve    = 8'(STARVE_LIMIT);

    logic [2:0] r_phase;
    logic [2:0] r_pat;
    logic [7:0] r_run;
    logic       r_car_d;
    logic       r_free_green;

    logic       w_enc_err;
    logic [2:0] w_pat;
    logic       w_changed;
    logic [7:0] w_run_next;
    logic [2:0] w_succ_pat;
    logic [2:0] w_succ_phase;
    logic [2:0] w_phase_next;
    logic       w_seq_err;
    logic       w_leaving;
    logic       w_len_ok;
    logic       w_tim_err;
    logic       w_nocar_err;
    logic       w_starve_err;
    logic       w_any_err;
    logic [2:0] w_code;

    // Pattern decode: anything not one-hot, or with no red side, is an encoding fault.
    always_comb begin
        w_enc_err = !$onehot(hw_light) || !$onehot(lr_light) ||
                    ((hw_light != c_red) && (lr_light != c_red));
        w_pat = c_pat_bad;
        if (!w_enc_err) begin
            if (lr_light == c_red) begin
                case (hw_light)
                    c_green: w_pat = c_pat_hwg;
                    c_yel:   w_pat = c_pat_hwy;
                    default: w_pat = c_pat_red;
                endcase
            end else begin
                w_pat = (lr_light == c_green) ? c_pat_lrg : c_pat_lry;
            end
        end
    end

    assign w_changed  = (w_pat != r_pat);
    assign w_run_next = w_changed ? 8'd1 : ((r_run == 8'hFF) ? 8'hFF : r_run + 8'd1);

    always_comb begin
        w_succ_pat   = c_pat_hwg;
        w_succ_phase = c_ph_hwg;
        case (r_phase)
            c_ph_hwg:  begin w_succ_pat = c_pat_hwy; w_succ_phase = c_ph_hwy;  end
            c_ph_hwy:  begin w_succ_pat = c_pat_red; w_succ_phase = c_ph_red1; end
            c_ph_red1: begin w_succ_pat = c_pat_lrg; w_succ_phase = c_ph_lrg;  end
            c_ph_lrg:  begin w_succ_pat = c_pat_lry; w_succ_phase = c_ph_lry;  end
            c_ph_lry:  begin w_succ_pat = c_pat_red; w_succ_phase = c_ph_red2; end
            default:   begin w_succ_pat = c_pat_hwg; w_succ_phase = c_ph_hwg;  end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= c_ph_idle;
            r_pat        <= c_pat_none;
            r_run        <= 8'd0;
            r_car_d      <= 1'b0;
            r_free_green <= 1'b0;
        end else begin
            r_phase <= w_phase_next;
            r_pat   <= w_pat;
            r_run   <= w_run_next;
            r_car_d <= lr_has_car;
            // The first green after resync has an unknown start, so its length is not judged.
            if (r_phase == c_ph_idle && w_phase_next == c_ph_hwg) begin
                r_free_green <= 1'b1;
            end else if (w_leaving && r_phase == c_ph_red2) begin
                r_free_green <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_phase_next = r_phase;
        w_seq_err    = 1'b0;
        w_leaving    = 1'b0;
        if (r_phase == c_ph_idle) begin
            if (w_pat == c_pat_hwg) begin
                w_phase_next = c_ph_hwg;
            end
        end else if (w_enc_err) begin
            w_phase_next = c_ph_idle;
        end else if (w_changed) begin
            if (w_pat == w_succ_pat) begin
                w_phase_next = w_succ_phase;
                w_leaving    = 1'b1;
            end else begin
                w_seq_err    = 1'b1;
                w_phase_next = c_ph_idle;
            end
        end
    end

    // Violation detection and priority encode
    always_comb begin
        case (r_phase)
            c_ph_hwg:            w_len_ok = r_free_green || (r_run >= c_green_min);
            c_ph_hwy, c_ph_lry:  w_len_ok = (r_run == c_yellow);
            c_ph_red1, c_ph_red2: w_len_ok = (r_run == c_allred);
            c_ph_lrg:            w_len_ok = (r_run == c_lr_green);
            default:             w_len_ok = 1'b1;
        endcase
        w_tim_err    = w_leaving && !w_len_ok;
        w_nocar_err  = w_leaving && (r_phase == c_ph_hwg) && !r_car_d;
        w_starve_err = (r_phase == c_ph_hwg) && !w_enc_err && !w_changed &&
                       lr_has_car && (w_run_next == c_starve);
        w_any_err    = w_enc_err || w_seq_err || w_tim_err || w_nocar_err || w_starve_err;
        if (w_enc_err)         w_code = c_code_enc;
        else if (w_seq_err)    w_code = c_code_seq;
        else if (w_tim_err)    w_code = c_code_timing;
        else if (w_nocar_err)  w_code = c_code_nocar;
        else if (w_starve_err) w_code = c_code_starve;
        else                   w_code = c_code_none;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= 1'b0;
            err_code  <= c_code_none;
            err_pulse <= 1'b0;
            err_count <= 8'd0;
        end else begin
            err_pulse <= w_any_err;
            if (w_any_err) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (!err) begin
                    err      <= 1'b1;
                    err_code <= w_code;
                end
            end
        end
    end

    assign phase = r_phase;

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: scenario-driven scoreboard bench for the light monitor.
`default_nettype none

module tb_traffic_light_monitor;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    typedef struct packed {
        logic [2:0]  ph;
        logic        pulse;
        logic [11:0] sticky;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] hw_light = R;
    logic [2:0] lr_light = R;
    logic       lr_has_car = 1'b0;
    logic [2:0] phase;
    logic       err;
    logic [2:0] err_code;
    logic       err_pulse;
    logic [7:0] err_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2:0] exp_code  = 3'd0;
    logic [7:0] exp_count = 8'd0;
    exp_t sb[$];

    traffic_light_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hw_light   (hw_light),
        .lr_light   (lr_light),
        .lr_has_car (lr_has_car),
        .phase      (phase),
        .err        (err),
        .err_code   (err_code),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // code = 0 means the sample is clean; otherwise a pulse with that code is expected.
    task automatic drive(input logic [2:0] hw, input logic [2:0] lr, input logic car,
                         input logic [2:0] ph, input logic [2:0] code);
        exp_t e;
        @(negedge clk);
        hw_light   = hw;
        lr_light   = lr;
        lr_has_car = car;
        if (code != 3'd0) begin
            if (exp_count != 8'hFF) exp_count = exp_count + 8'd1;
            if (exp_code == 3'd0) exp_code = code;
        end
        e.ph     = ph;
        e.pulse  = (code != 3'd0);
        e.sticky = {1'b0, (exp_code != 3'd0), exp_code, exp_count};
        sb.push_back(e);
    endtask

    task automatic seg(input logic [2:0] hw, input logic [2:0] lr, input int n,
                       input int car_from, input logic [2:0] ph);
        for (int i = 1; i <= n; i++) drive(hw, lr, (i >= car_from), ph, 3'd0);
    endtask

    // Lights after a full clean cycle starting just after the green.
    task automatic rest_of_round;
        seg(Y, R, 20, 1, 3'd2);
        seg(R, R, 1, 1, 3'd3);
        seg(R, G, 80, 999, 3'd4);
        seg(R, Y, 20, 999, 3'd5);
        seg(R, R, 1, 999, 3'd6);
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_phase", 32'(phase), 32'd0);
        check_val("rst_pulse", 32'(err_pulse), 32'd0);
        check_val("rst_sticky", 32'({err, err_code, err_count}), 32'd0);
        exp_code  = 3'd0;
        exp_count = 8'd0;
        hw_light  = R;
        lr_light  = R;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val("phase", 32'(phase), 32'(e.ph));
            check_val("err_pulse", 32'(err_pulse), 32'(e.pulse));
            check_val("err/code/count", 32'({err, err_code, err_count}), 32'(e.sticky[11:0]));
        end
    end

    initial begin
        // Nominal: three clean rounds, first green unjudged
        do_reset();
        for (int r = 0; r < 3; r++) begin
            seg(G, R, 80, 50, 3'd1);
            rest_of_round();
        end
        seg(G, R, 3, 50, 3'd1);

        // Short highway yellow
        do_reset();
        seg(G, R, 80, 50, 3'd1);
        seg(Y, R, 19, 1, 3'd2);
        drive(R, R, 1'b1, 3'd3, 3'd3);
        seg(R, G, 80, 999, 3'd4);
        seg(R, Y, 20, 999, 3'd5);
        seg(R, R, 1, 999, 3'd6);
        seg(G, R, 5, 999, 3'd1);

        // Illegal encoding mid local-road green, then resync
        do_reset();
        seg(G, R, 80, 50, 3'd1);
        seg(Y, R, 20, 1, 3'd2);
        seg(R, R, 1, 1, 3'd3);
        seg(R, G, 30, 999, 3'd4);
        drive(3'b110, G, 1'b0, 3'd0, 3'd1);
        seg(R, G, 49, 999, 3'd0);
        seg(R, Y, 20, 999, 3'd0);
        seg(R, R, 1, 999, 3'd0);
        seg(G, R, 80, 50, 3'd1);
        seg(Y, R, 20, 1, 3'd2);
        seg(R, R, 1, 1, 3'd3);
        seg(R, G, 5, 999, 3'd4);

        // NOCAR, then STARVE in a later long green
        do_reset();
        seg(G, R, 80, 999, 3'd1);
        drive(Y, R, 1'b0, 3'd2, 3'd4);
        seg(Y, R, 19, 999, 3'd2);
        seg(R, R, 1, 999, 3'd3);
        seg(R, G, 80, 999, 3'd4);
        seg(R, Y, 20, 999, 3'd5);
        seg(R, R, 1, 999, 3'd6);
        for (int i = 1; i <= 150; i++)
            drive(G, R, 1'b1, 3'd1, (i == 100) ? 3'd5 : 3'd0);
        seg(Y, R, 20, 1, 3'd2);
        seg(R, R, 1, 1, 3'd3);

        // Saturation through repeated sequence faults, then async reset mid LR_Y
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(G, R, 1'b0, 3'd1, 3'd0);
            drive(R, R, 1'b0, 3'd0, 3'd2);
        end
        seg(G, R, 80, 50, 3'd1);
        seg(Y, R, 20, 1, 3'd2);
        seg(R, R, 1, 1, 3'd3);
        seg(R, G, 80, 999, 3'd4);
        seg(R, Y, 10, 999, 3'd5);
        @(negedge clk);
        check_val("pre_reset_count", 32'(err_count), 32'd255);
        do_reset();
        seg(R, Y, 10, 999, 3'd0);
        seg(R, R, 1, 999, 3'd0);
        seg(G, R, 5, 999, 3'd1);

        @(negedge clk);
        @(negedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive protocol checker on the light interface of the traffic light controller. It samples `hw_light`, `lr_light` and `lr_has_car` every cycle and rebuilds the controller's phase sequence from the light patterns alone. It checks encoding, phase order, phase durations and the car-request rule, and reports violations through sticky and pulsed error outputs. It is instantiated beside the controller on the board/bench and drives no traffic signals.

## Interface
- `GREEN_MIN`, 80: minimum highway-green run (cycles) before yellow is allowed
- `LR_GREEN_LEN`, 80: exact local-road green run (cycles)
- `YELLOW_LEN`, 20: exact yellow run, both roads
- `ALLRED_LEN`, 1: exact all-red run, both gaps
- `STARVE_LIMIT`, 100: max highway-green run while `lr_has_car`=1 before flagging starvation
- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `hw_light`  in  3  highway light, {G,Y,R}: 100 green, 010 yellow, 001 red
- `lr_light`  in  3  local-road light, same encoding
- `lr_has_car`  in  1  car request seen by the controller
- `phase`  out  3  decoded phase: 0 IDLE, 1 HW_G, 2 HW_Y, 3 RED1, 4 LR_G, 5 LR_Y, 6 RED2
- `err`  out  1  sticky, set on first violation
- `err_code`  out  3  code of first violation: 0 none, 1 ENCODING, 2 SEQUENCE, 3 TIMING, 4 NOCAR, 5 STARVE
- `err_pulse`  out  1  one-cycle pulse per violating sample
- `err_count`  out  8  violations seen, saturates at 255

## Operation
- Pattern map: (100,001) HW_G; (010,001) HW_Y; (001,001) RED; (001,100) LR_G; (001,010) LR_Y. RED resolves to RED1 after HW_Y and to RED2 after LR_Y.
- `run`: 8-bit count of consecutive samples of the current pattern. It loads 1 on a pattern change and saturates at 255.
- IDLE: entered at reset and after ENCODING or SEQUENCE errors. Waits for the HW_G pattern, then enters HW_G. No duration check applies to that first green.
- Legal order: HW_G→HW_Y→RED1→LR_G→LR_Y→RED2→HW_G.
- Checks on each sample:
  - ENCODING: either light not one-hot, or both lights non-red.
  - SEQUENCE: pattern changed to anything other than the legal successor.
  - TIMING: on leaving a phase, the finished run length violates its rule: HW_G < GREEN_MIN; HW_Y or LR_Y ≠ YELLOW_LEN; RED1 or RED2 ≠ ALLRED_LEN; LR_G ≠ LR_GREEN_LEN. On a TIMING error the phase still advances.
  - NOCAR: on HW_G→HW_Y, `lr_has_car` was 0 at the previous sample.
  - STARVE: in HW_G with pattern unchanged, `lr_has_car`=1, and `run` reaches STARVE_LIMIT. Flags once per HW_G phase.
- Several violations on one sample: one pulse, `err_count` +1. Code is chosen by priority ENCODING > SEQUENCE > TIMING > NOCAR > STARVE.
- `err_code` latches only while `err`=0. `err`, `err_code` and `err_count` clear only on reset.
- ENCODING and SEQUENCE force `phase` to IDLE on the next cycle. In IDLE only ENCODING is checked.

## Timing
- Reset (async assert): `phase`=0, `err`=0, `err_code`=0, `err_pulse`=0, `err_count`=0, `run`=0. Deassertion is synchronized by the system.
- All outputs are registered. A violation sampled at edge k is visible on outputs after edge k: `err_pulse` is high for cycle k..k+1, and `phase` updates at the same edge.
- `phase` reflects the pattern sampled at the last edge (1-cycle latency from the lights).
- Reset mid-phase: all state is dropped and the monitor resyncs in IDLE. No error is raised for the truncated phase.
- `run` saturation: runs ≥255 compare as 255. Parameters must be < 255.

## Test plan
- Nominal: the controller's full cycle, car asserted at cycle 50, HW_G 80, HW_Y 20, RED1 1, LR_G 80, LR_Y 20, RED2 1, three rounds → `err`=0, `phase` steps 1,2,3,4,5,6,1.
- Short yellow: HW_Y held 19 cycles → `err_pulse` once on the RED1 sample, `err_code`=3, `err_count`=1, `phase`=3.
- Illegal encoding: `hw_light`=110 for one cycle during LR_G → `err_code`=1, `phase`=0. Monitor resyncs at the next HW_G, with no further errors.
- NOCAR then STARVE: HW_G→HW_Y with `lr_has_car`=0 → code 4. Then a new round with car held from cycle 1 and green kept 150 cycles → second error at run 100, `err_count`=2, `err_code` stays 4.
- Saturation/reset: inject 300 SEQUENCE violations → `err_count`=255. Assert `rst_n`=0 mid-LR_Y → all outputs 0 immediately, asynchronously.
